// File: rtl/pipe_pkg.sv
// Shared definitions for the pipeline hazard controller.
// Holds the Tuse/Tnew encodings, forwarding-select constants, the MDU latency
// defaults, the busy counter width and two small helpers used by the top:
//   hz_raw  - true when a source register must wait for a producer's Tnew
//   fwd_sel - picks the forwarding source for one operand (M before W)
package pipe_pkg;

   localparam logic [1:0] TUSE_0    = 2'd0;
   localparam logic [1:0] TUSE_1    = 2'd1;
   localparam logic [1:0] TUSE_NONE = 2'd3;

   localparam logic [1:0] TNEW_0 = 2'd0;
   localparam logic [1:0] TNEW_1 = 2'd1;
   localparam logic [1:0] TNEW_2 = 2'd2;

   localparam logic [1:0] FWD_NONE = 2'd0;
   localparam logic [1:0] FWD_M    = 2'd1;
   localparam logic [1:0] FWD_W    = 2'd2;

   localparam int MULT_CYC_DEF = 5;
   localparam int DIV_CYC_DEF  = 10;

   localparam int CTR_W   = 4;
   localparam int CTR_MAX = 15;

   // TUSE_NONE (3) can never be below a Tnew of 0..2, so unused operands
   // fall out of the plain compare without a separate check.
   function automatic logic hz_raw(input logic [4:0] src, input logic [1:0] tuse,
                                   input logic [4:0] wa,  input logic [1:0] tnew);
      return (src != 5'd0) && (src == wa) && (tuse < tnew);
   endfunction

   function automatic logic [1:0] fwd_sel(input logic [4:0] src,
                                          input logic [4:0] m_wa, input logic [1:0] m_tnew,
                                          input logic [4:0] w_wa);
      if (src == 5'd0)                          return FWD_NONE;
      else if (src == m_wa && m_tnew == TNEW_0) return FWD_M;
      else if (src == w_wa)                     return FWD_W;
      else                                      return FWD_NONE;
   endfunction

endpackage

// File: rtl/md_busy_ctr.sv
// MDU busy down-counter.
// Loads the mult or div latency when an MDU operation starts, then counts down
// to zero; busy is high while the count is non-zero. Latencies above the
// 4-bit range saturate to 15.
// Ports:
//   clk, reset (sync, active-high)
//   start  - mult/div issued this cycle (reloads even when already busy)
//   isDiv  - 1 selects DIV_CYC, 0 selects MULT_CYC
//   busy   - counter non-zero
module md_busy_ctr
   import pipe_pkg::*;
#(
   parameter int MULT_CYC = MULT_CYC_DEF,
   parameter int DIV_CYC  = DIV_CYC_DEF
) (
   input  logic clk,
   input  logic reset,
   input  logic start,
   input  logic isDiv,
   output logic busy
);

   localparam logic [CTR_W-1:0] MULT_LD = (MULT_CYC > CTR_MAX) ? CTR_W'(CTR_MAX) : CTR_W'(MULT_CYC);
   localparam logic [CTR_W-1:0] DIV_LD  = (DIV_CYC  > CTR_MAX) ? CTR_W'(CTR_MAX) : CTR_W'(DIV_CYC);

   logic [CTR_W-1:0] cnt_q;

   always_ff @(posedge clk) begin
      if (reset)
         cnt_q <= '0;
      else if (start)
         cnt_q <= isDiv ? DIV_LD : MULT_LD;
      else if (cnt_q != '0)
         cnt_q <= cnt_q - 1'b1;
   end

   assign busy = (cnt_q != '0);

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard controller: stall generation, operand forwarding selects and
// MDU busy tracking for a 5-stage pipeline. All hazard and forwarding logic is
// combinational; the only state is the MDU busy counter (md_busy_ctr) and,
// when HAZARD_PERF_EN is defined, a saturating 32-bit stall-cycle counter.
// Ports:
//   clk, reset (sync, active-high)
//   D_*  - D-stage sources, Tuse per operand, MDU-class flag
//   E_*  - E-stage sources, destination/Tnew, MDU start/div
//   M_*  - M-stage rt source, destination/Tnew
//   W_wa - W-stage destination
//   stall, D_fwdRs/Rt, E_fwdRs/Rt, M_fwdRt, mdBusy
//   stallCnt (HAZARD_PERF_EN only) - cycles spent stalled, saturating
module pipe_hazard_ctrl
   import pipe_pkg::*;
#(
   parameter int MULT_CYC = MULT_CYC_DEF,
   parameter int DIV_CYC  = DIV_CYC_DEF
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [4:0]  D_rsAddr,
   input  logic [4:0]  D_rtAddr,
   input  logic [1:0]  D_tuseRs,
   input  logic [1:0]  D_tuseRt,
   input  logic        D_isMd,
   input  logic [4:0]  E_rsAddr,
   input  logic [4:0]  E_rtAddr,
   input  logic [4:0]  E_wa,
   input  logic [1:0]  E_tnew,
   input  logic        E_mdStart,
   input  logic        E_mdDiv,
   input  logic [4:0]  M_rtAddr,
   input  logic [4:0]  M_wa,
   input  logic [1:0]  M_tnew,
   input  logic [4:0]  W_wa,
   output logic        stall,
   output logic [1:0]  D_fwdRs,
   output logic [1:0]  D_fwdRt,
   output logic [1:0]  E_fwdRs,
   output logic [1:0]  E_fwdRt,
   output logic        M_fwdRt,
   output logic        mdBusy
`ifdef HAZARD_PERF_EN
   ,
   output logic [31:0] stallCnt
`endif
);

   logic stall_e;
   logic stall_m;
   logic stall_md;

   md_busy_ctr #(
      .MULT_CYC (MULT_CYC),
      .DIV_CYC  (DIV_CYC)
   ) u_md_busy_ctr (
      .clk   (clk),
      .reset (reset),
      .start (E_mdStart),
      .isDiv (E_mdDiv),
      .busy  (mdBusy)
   );

   always_comb begin
      stall_e  = hz_raw(D_rsAddr, D_tuseRs, E_wa, E_tnew) ||
                 hz_raw(D_rtAddr, D_tuseRt, E_wa, E_tnew);
      stall_m  = hz_raw(D_rsAddr, D_tuseRs, M_wa, M_tnew) ||
                 hz_raw(D_rtAddr, D_tuseRt, M_wa, M_tnew);
      // The op issuing in E this cycle has not reached the counter yet.
      stall_md = D_isMd && (mdBusy || E_mdStart);
      stall    = stall_e || stall_m || stall_md;
   end

   assign D_fwdRs = fwd_sel(D_rsAddr, M_wa, M_tnew, W_wa);
   assign D_fwdRt = fwd_sel(D_rtAddr, M_wa, M_tnew, W_wa);
   assign E_fwdRs = fwd_sel(E_rsAddr, M_wa, M_tnew, W_wa);
   assign E_fwdRt = fwd_sel(E_rtAddr, M_wa, M_tnew, W_wa);
   assign M_fwdRt = (M_rtAddr != 5'd0) && (M_rtAddr == W_wa);

`ifdef HAZARD_PERF_EN
   logic [31:0] stall_cnt_q;

   always_ff @(posedge clk) begin
      if (reset)
         stall_cnt_q <= '0;
      else if (stall && (stall_cnt_q != 32'hFFFF_FFFF))
         stall_cnt_q <= stall_cnt_q + 32'd1;
   end

   assign stallCnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
module tb_pipe_hazard_ctrl;

   localparam int MULT = 5;
   localparam int DIV  = 10;

   logic        clk = 1'b0;
   logic        reset;
   logic [4:0]  D_rsAddr, D_rtAddr, E_rsAddr, E_rtAddr, E_wa, M_rtAddr, M_wa, W_wa;
   logic [1:0]  D_tuseRs, D_tuseRt, E_tnew, M_tnew;
   logic        D_isMd, E_mdStart, E_mdDiv;
   logic        stall, M_fwdRt, mdBusy;
   logic [1:0]  D_fwdRs, D_fwdRt, E_fwdRs, E_fwdRt;
`ifdef HAZARD_PERF_EN
   logic [31:0] stallCnt;
`endif

   int n_tot  = 0;
   int n_pass = 0;

   // reference model state: cycle number, last MDU start cycle and its latency
   int          cyc      = 0;
   int          md_start = 0;
   int          md_lat   = 0;
   logic [31:0] ref_cnt  = 0;

   always #5 clk = ~clk;

   pipe_hazard_ctrl #(.MULT_CYC(MULT), .DIV_CYC(DIV)) dut (
      .clk       (clk),
      .reset     (reset),
      .D_rsAddr  (D_rsAddr),
      .D_rtAddr  (D_rtAddr),
      .D_tuseRs  (D_tuseRs),
      .D_tuseRt  (D_tuseRt),
      .D_isMd    (D_isMd),
      .E_rsAddr  (E_rsAddr),
      .E_rtAddr  (E_rtAddr),
      .E_wa      (E_wa),
      .E_tnew    (E_tnew),
      .E_mdStart (E_mdStart),
      .E_mdDiv   (E_mdDiv),
      .M_rtAddr  (M_rtAddr),
      .M_wa      (M_wa),
      .M_tnew    (M_tnew),
      .W_wa      (W_wa),
      .stall     (stall),
      .D_fwdRs   (D_fwdRs),
      .D_fwdRt   (D_fwdRt),
      .E_fwdRs   (E_fwdRs),
      .E_fwdRt   (E_fwdRt),
      .M_fwdRt   (M_fwdRt),
      .mdBusy    (mdBusy)
`ifdef HAZARD_PERF_EN
      ,
      .stallCnt  (stallCnt)
`endif
   );

   function automatic int min15(input int v);
      return (v > 15) ? 15 : v;
   endfunction

   // MDU busy in cycles start+1 .. start+latency
   function automatic bit ref_busy();
      return (md_lat > 0) && (cyc > md_start) && (cyc <= md_start + md_lat);
   endfunction

   function automatic bit needs_wait(input int src, input int tuse, input int wa, input int tnew);
      return (src != 0) && (src == wa) && (tuse < tnew);
   endfunction

   function automatic bit ref_stall();
      return needs_wait(D_rsAddr, D_tuseRs, E_wa, E_tnew) || needs_wait(D_rtAddr, D_tuseRt, E_wa, E_tnew) ||
             needs_wait(D_rsAddr, D_tuseRs, M_wa, M_tnew) || needs_wait(D_rtAddr, D_tuseRt, M_wa, M_tnew) ||
             (D_isMd && (ref_busy() || E_mdStart));
   endfunction

   function automatic int ref_fwd(input int src);
      if (src == 0) return 0;
      if (src == M_wa && M_tnew == 0) return 1;
      if (src == W_wa) return 2;
      return 0;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tot++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s observed=%0h expected=%0h (cycle %0d)", tag, obs, exp, cyc);
   endtask

   task automatic chk_all(input string tag);
      chk({tag, ".stall"},   32'(stall),   32'(ref_stall()));
      chk({tag, ".D_fwdRs"}, 32'(D_fwdRs), 32'(ref_fwd(D_rsAddr)));
      chk({tag, ".D_fwdRt"}, 32'(D_fwdRt), 32'(ref_fwd(D_rtAddr)));
      chk({tag, ".E_fwdRs"}, 32'(E_fwdRs), 32'(ref_fwd(E_rsAddr)));
      chk({tag, ".E_fwdRt"}, 32'(E_fwdRt), 32'(ref_fwd(E_rtAddr)));
      chk({tag, ".M_fwdRt"}, 32'(M_fwdRt), 32'((M_rtAddr != 0) && (M_rtAddr == W_wa)));
      chk({tag, ".mdBusy"},  32'(mdBusy),  32'(ref_busy()));
   endtask

   task automatic tick();
      bit exp_st;
      exp_st = ref_stall();
      @(posedge clk);
      if (reset) begin
         md_lat  = 0;
         ref_cnt = 0;
      end else begin
         if (E_mdStart) begin
            md_start = cyc;
            md_lat   = E_mdDiv ? min15(DIV) : min15(MULT);
         end
         if (exp_st && ref_cnt != 32'hFFFF_FFFF) ref_cnt = ref_cnt + 1;
      end
      cyc++;
      #1;
   endtask

   task automatic set_idle();
      reset = 0;
      D_rsAddr = 0; D_rtAddr = 0; D_tuseRs = 3; D_tuseRt = 3; D_isMd = 0;
      E_rsAddr = 0; E_rtAddr = 0; E_wa = 0; E_tnew = 0; E_mdStart = 0; E_mdDiv = 0;
      M_rtAddr = 0; M_wa = 0; M_tnew = 0; W_wa = 0;
   endtask

   initial begin
      set_idle();
      reset = 1;
      #1;
      tick();
      tick();
      reset = 0;
      #1;
      chk("reset.mdBusy", 32'(mdBusy), 32'd0);
      chk("reset.stall",  32'(stall),  32'd0);
      chk_all("reset");

      // E-stage load-use: Tnew 2 vs Tuse 0 stalls, Tnew 1 vs Tuse 1 does not
      E_wa = 5; E_tnew = 2; D_rsAddr = 5; D_tuseRs = 0; #1;
      chk("e_hz_stall", 32'(stall), 32'd1);
      chk_all("e_hz");
      E_tnew = 1; D_tuseRs = 1; #1;
      chk("e_hz_nostall", 32'(stall), 32'd0);
      tick();
      set_idle();

      // E forwarding priority: M over W, W alone, nothing on r0
      M_wa = 8; M_tnew = 0; W_wa = 8; E_rsAddr = 8; #1;
      chk("fwd_m", 32'(E_fwdRs), 32'd1);
      M_wa = 0; #1;
      chk("fwd_w", 32'(E_fwdRs), 32'd2);
      W_wa = 0; E_rsAddr = 0; #1;
      chk("fwd_zero", 32'(E_fwdRs), 32'd0);
      chk_all("fwd");

      // register 0 never stalls or forwards
      D_rtAddr = 0; D_tuseRt = 0; E_wa = 0; E_tnew = 2; #1;
      chk("r0_stall", 32'(stall),   32'd0);
      chk("r0_fwd",   32'(D_fwdRt), 32'd0);
      tick();
      set_idle();

      // div start with MD instruction held in D
      D_isMd = 1; E_mdStart = 1; E_mdDiv = 1; #1;
      chk("div_c0_stall", 32'(stall), 32'd1);
      tick();
      E_mdStart = 0; E_mdDiv = 0;
      for (int i = 1; i <= 10; i++) begin
         #1;
         chk($sformatf("div_c%0d_stall", i), 32'(stall),  32'd1);
         chk($sformatf("div_c%0d_busy", i),  32'(mdBusy), 32'd1);
         chk_all("div");
         tick();
      end
      #1;
      chk("div_c11_busy",  32'(mdBusy), 32'd0);
      chk("div_c11_stall", 32'(stall),  32'd0);
      set_idle();
      tick();

      // mult abandoned by reset at cycle 2
      D_isMd = 1; E_mdStart = 1; #1;
      tick();
      E_mdStart = 0; #1;
      chk("mrst_c1_busy", 32'(mdBusy), 32'd1);
      tick();
      reset = 1; #1;
      chk_all("mrst_c2");
      tick();
      reset = 0; #1;
      chk("mrst_c3_busy",  32'(mdBusy), 32'd0);
      chk("mrst_c3_stall", 32'(stall),  32'd0);
      set_idle();

`ifdef HAZARD_PERF_EN
      reset = 1; tick(); reset = 0;
      E_wa = 5; E_tnew = 2; D_rsAddr = 5; D_tuseRs = 0;
      for (int i = 0; i < 7; i++) tick();
      set_idle(); #1;
      chk("stallcnt7", stallCnt, 32'd7);
      tick();
      chk("stallcnt7_hold", stallCnt, 32'd7);
`endif

      // random traffic, small register pool to make collisions frequent
      for (int i = 0; i < 400; i++) begin
         reset     = ($urandom_range(0, 49) == 0);
         D_rsAddr  = 5'($urandom_range(0, 3));
         D_rtAddr  = 5'($urandom_range(0, 3));
         D_tuseRs  = ($urandom_range(0, 2) == 2) ? 2'd3 : 2'($urandom_range(0, 1));
         D_tuseRt  = ($urandom_range(0, 2) == 2) ? 2'd3 : 2'($urandom_range(0, 1));
         D_isMd    = 1'($urandom_range(0, 1));
         E_rsAddr  = 5'($urandom_range(0, 3));
         E_rtAddr  = 5'($urandom_range(0, 3));
         E_wa      = 5'($urandom_range(0, 3));
         E_tnew    = 2'($urandom_range(0, 2));
         E_mdStart = ($urandom_range(0, 7) == 0);
         E_mdDiv   = 1'($urandom_range(0, 1));
         M_rtAddr  = 5'($urandom_range(0, 3));
         M_wa      = 5'($urandom_range(0, 3));
         M_tnew    = 2'($urandom_range(0, 1));
         W_wa      = 5'($urandom_range(0, 3));
         #1;
         chk_all("rand");
         tick();
      end
`ifdef HAZARD_PERF_EN
      chk("rand_stallcnt", stallCnt, ref_cnt);
`endif

      $display("%0d/%0d checks passed", n_pass, n_tot);
      $finish;
   end

endmodule
